// File: rtl/program_sequencer.sv
// -----------------------------------------------------------------------------
// program_sequencer
//   Generates the program-memory fetch address every cycle. It supports:
//     - increment;
//     - absolute and relative branch;
//     - call/return through a hardware return-address stack;
//     - a fetch stall;
//     - sticky stack overflow and underflow flags.
//   All outputs are registered, so there is no combinational input-to-output path.
//
// Parameters
//   P_SIZE       program address width (memory depth 2**P_SIZE)
//   STACK_DEPTH  return-address stack entries (>= 1)
//   RESET_ADDR   address loaded on reset
//
// Ports
//   clk, nRst       clock (rising edge), asynchronous active-low reset
//   inc             advance to address+1
//   branchAbs       jump to branchAddress
//   branchRel       jump to address + signed(branchAddress)
//   call            push address+1 and jump to branchAddress
//   ret             pop the top of stack into address
//   stall           hold all state this cycle and ignore commands
//   branchAddress   absolute target, or two's-complement offset
//   address         current fetch address
//   depth           number of entries on the stack
//   stackOverflow   sticky: call issued while the stack was full
//   stackUnderflow  sticky: ret issued while the stack was empty
//
// Optional feature (macro SEQ_LOOP_EN)
//   Adds a zero-overhead hardware loop. The extra ports are:
//     - loopSet (in)
//     - loopCount[7:0] (in)
//     - loopActive (out)
//   Command priority, highest first:
//     loopSet > ret > call > branchAbs > branchRel > inc
// -----------------------------------------------------------------------------
module program_sequencer #(
    parameter int          P_SIZE      = 6,
    parameter int          STACK_DEPTH = 4,
    parameter int unsigned RESET_ADDR  = 0
) (
    input  logic                               clk,
    input  logic                               nRst,
    input  logic                               inc,
    input  logic                               branchAbs,
    input  logic                               branchRel,
    input  logic                               call,
    input  logic                               ret,
    input  logic                               stall,
    input  logic [P_SIZE-1:0]                  branchAddress,
    output logic [P_SIZE-1:0]                  address,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               stackOverflow,
    output logic                               stackUnderflow
`ifdef SEQ_LOOP_EN
    ,
    input  logic                               loopSet,
    input  logic [7:0]                         loopCount,
    output logic                               loopActive
`endif
);

    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_DEPTH);
    localparam logic [P_SIZE-1:0]  RST_ADDR   = P_SIZE'(RESET_ADDR);

    logic [P_SIZE-1:0]  address_q, address_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;

    logic [P_SIZE-1:0]  stack_q [STACK_DEPTH];
    logic               push_en;
    logic [IDX_W-1:0]   push_idx;
    logic [IDX_W-1:0]   pop_idx;
    logic [P_SIZE-1:0]  addr_plus1;

    // While the stack is not full, depth is a valid index for the next free slot.
    // While the stack is not empty, depth-1 is the index of the top entry.
    assign push_idx   = depth_q[IDX_W-1:0];
    assign pop_idx    = IDX_W'(depth_q - DEPTH_W'(1));
    assign addr_plus1 = address_q + P_SIZE'(1);

`ifdef SEQ_LOOP_EN
    logic [P_SIZE-1:0] loop_start_q, loop_start_d;
    logic [P_SIZE-1:0] loop_end_q, loop_end_d;
    logic [7:0]        loop_count_q, loop_count_d;
    logic              loop_active_q, loop_active_d;
`endif

    // NOTE: every variable written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        address_d   = address_q;
        depth_d     = depth_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        push_en     = 1'b0;
`ifdef SEQ_LOOP_EN
        loop_start_d  = loop_start_q;
        loop_end_d    = loop_end_q;
        loop_count_d  = loop_count_q;
        loop_active_d = loop_active_q;
`endif

        if (!stall) begin
`ifdef SEQ_LOOP_EN
            if (loopSet) begin
                // A new loopSet replaces any loop in progress; loops do not nest.
                loop_start_d  = addr_plus1;
                loop_end_d    = branchAddress;
                loop_count_d  = loopCount;
                loop_active_d = (loopCount != 8'd0);
                address_d     = addr_plus1;
            end else
`endif
            if (ret) begin
                if (depth_q != '0) begin
                    address_d = stack_q[pop_idx];
                    depth_d   = depth_q - DEPTH_W'(1);
                end else begin
                    underflow_d = 1'b1;
                end
            end else if (call) begin
                if (depth_q != DEPTH_FULL) begin
                    push_en   = 1'b1;
                    depth_d   = depth_q + DEPTH_W'(1);
                    address_d = branchAddress;
                end else begin
                    overflow_d = 1'b1;
                end
            end else if (branchAbs) begin
                address_d = branchAddress;
            end else if (branchRel) begin
                // Same-width add wraps modulo 2**P_SIZE, which gives signed-offset
                // semantics for free.
                address_d = address_q + branchAddress;
            end else if (inc) begin
                address_d = addr_plus1;
`ifdef SEQ_LOOP_EN
                if (loop_active_q && (address_q == loop_end_q)) begin
                    // loopCount==0 never activates a loop, so count>=1 here.
                    if (loop_count_q > 8'd1) begin
                        address_d    = loop_start_q;
                        loop_count_d = loop_count_q - 8'd1;
                    end else begin
                        loop_count_d  = 8'd0;
                        loop_active_d = 1'b0;
                    end
                end
`endif
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples values from before the clock edge.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            address_q   <= RST_ADDR;
            depth_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            address_q   <= address_d;
            depth_q     <= depth_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // NOTE: the stack storage has no reset. Its contents are don't-care until a
    // push, and depth alone determines which entries are valid.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_q[push_idx] <= addr_plus1;
        end
    end

`ifdef SEQ_LOOP_EN
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            loop_start_q  <= '0;
            loop_end_q    <= '0;
            loop_count_q  <= 8'd0;
            loop_active_q <= 1'b0;
        end else begin
            loop_start_q  <= loop_start_d;
            loop_end_q    <= loop_end_d;
            loop_count_q  <= loop_count_d;
            loop_active_q <= loop_active_d;
        end
    end

    assign loopActive = loop_active_q;
`endif

    assign address        = address_q;
    assign depth          = depth_q;
    assign stackOverflow  = overflow_q;
    assign stackUnderflow = underflow_q;

endmodule

// File: tb/tb_program_sequencer.sv
// -----------------------------------------------------------------------------
// tb_program_sequencer
//   Self-checking bench for program_sequencer, using the default parameters
//   (P_SIZE=6, STACK_DEPTH=4, RESET_ADDR=0). Inputs are driven on the falling
//   edge, and outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_program_sequencer;

    logic       clk;
    logic       nRst;
    logic       inc, branchAbs, branchRel, call, ret, stall;
    logic [5:0] branchAddress;
    logic [5:0] address;
    logic [2:0] depth;
    logic       stackOverflow, stackUnderflow;
`ifdef SEQ_LOOP_EN
    logic       loopSet;
    logic [7:0] loopCount;
    logic       loopActive;
`endif

    int n_checks = 0;
    int n_errors = 0;

    program_sequencer #(
        .P_SIZE     (6),
        .STACK_DEPTH(4),
        .RESET_ADDR (0)
    ) dut (
        .clk           (clk),
        .nRst          (nRst),
        .inc           (inc),
        .branchAbs     (branchAbs),
        .branchRel     (branchRel),
        .call          (call),
        .ret           (ret),
        .stall         (stall),
        .branchAddress (branchAddress),
        .address       (address),
        .depth         (depth),
        .stackOverflow (stackOverflow),
        .stackUnderflow(stackUnderflow)
`ifdef SEQ_LOOP_EN
        ,
        .loopSet       (loopSet),
        .loopCount     (loopCount),
        .loopActive    (loopActive)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       inc, abs_b, rel_b, call_b, ret_b, stall_b;
        logic [5:0] ba;
        logic [5:0] e_addr;
        logic [2:0] e_depth;
        logic       e_ovf, e_unf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic i, logic a, logic r, logic c,
                                logic rt, logic s, logic [5:0] ba,
                                logic [5:0] ea, logic [2:0] ed, logic eo, logic eu);
        vec_t v;
        v.name   = name;
        v.inc    = i;
        v.abs_b  = a;
        v.rel_b  = r;
        v.call_b = c;
        v.ret_b  = rt;
        v.stall_b = s;
        v.ba     = ba;
        v.e_addr = ea;
        v.e_depth = ed;
        v.e_ovf  = eo;
        v.e_unf  = eu;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic i, input logic a, input logic r, input logic c,
                         input logic rt, input logic s, input logic [5:0] ba);
        inc           = i;
        branchAbs     = a;
        branchRel     = r;
        call          = c;
        ret           = rt;
        stall         = s;
        branchAddress = ba;
`ifdef SEQ_LOOP_EN
        loopSet       = 1'b0;
        loopCount     = 8'd0;
`endif
    endtask

    // Drive the inputs on the falling edge, then sample after the next rising edge.
    task automatic step(input logic i, input logic a, input logic r, input logic c,
                        input logic rt, input logic s, input logic [5:0] ba);
        @(negedge clk);
        drive(i, a, r, c, rt, s, ba);
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string name, input logic [5:0] ea,
                               input logic [2:0] ed, input logic eo, input logic eu);
        check({name, ".address"}, 32'(address), 32'(ea));
        check({name, ".depth"}, 32'(depth), 32'(ed));
        check({name, ".overflow"}, 32'(stackOverflow), 32'(eo));
        check({name, ".underflow"}, 32'(stackUnderflow), 32'(eu));
    endtask

    initial begin
        // Starting point: address 6, empty stack, flags clear (after test 1 below).
        vecs.push_back(mk("abs10",     0,1,0,0,0,0, 6'd10,   6'd10, 3'd0, 0,0));
        vecs.push_back(mk("rel_m2",    0,0,1,0,0,0, 6'h3E,   6'd8,  3'd0, 0,0));
        vecs.push_back(mk("abs33",     0,1,0,0,0,0, 6'd33,   6'd33, 3'd0, 0,0));
        vecs.push_back(mk("rel_zero",  0,0,1,0,0,0, 6'd0,    6'd33, 3'd0, 0,0));
        vecs.push_back(mk("rel_m1",    0,0,1,0,0,0, 6'h3F,   6'd32, 3'd0, 0,0));
        vecs.push_back(mk("abs5",      0,1,0,0,0,0, 6'd5,    6'd5,  3'd0, 0,0));
        vecs.push_back(mk("call20",    0,0,0,1,0,0, 6'd20,   6'd20, 3'd1, 0,0));
        vecs.push_back(mk("call40",    0,0,0,1,0,0, 6'd40,   6'd40, 3'd2, 0,0));
        vecs.push_back(mk("ret_a",     0,0,0,0,1,0, 6'd0,    6'd21, 3'd1, 0,0));
        vecs.push_back(mk("ret_b",     0,0,0,0,1,0, 6'd0,    6'd6,  3'd0, 0,0));
        vecs.push_back(mk("pri_abs",   1,1,1,0,0,0, 6'd10,   6'd10, 3'd0, 0,0));
        vecs.push_back(mk("pri_rel",   1,0,1,0,0,0, 6'd2,    6'd12, 3'd0, 0,0));
        vecs.push_back(mk("pri_call",  0,1,0,1,0,0, 6'd50,   6'd50, 3'd1, 0,0));
        vecs.push_back(mk("idle",      0,0,0,0,0,0, 6'd7,    6'd50, 3'd1, 0,0));
        vecs.push_back(mk("pri_ret",   1,0,0,1,1,0, 6'd0,    6'd13, 3'd0, 0,0));
        vecs.push_back(mk("stall_inc", 1,0,0,0,0,1, 6'd0,    6'd13, 3'd0, 0,0));
        vecs.push_back(mk("abs63",     0,1,0,0,0,0, 6'd63,   6'd63, 3'd0, 0,0));
        vecs.push_back(mk("inc_wrap",  1,0,0,0,0,0, 6'd0,    6'd0,  3'd0, 0,0));

        // Fill the stack, then overflow it.
        vecs.push_back(mk("fill1",     0,0,0,1,0,0, 6'd1,    6'd1,  3'd1, 0,0));
        vecs.push_back(mk("fill2",     0,0,0,1,0,0, 6'd2,    6'd2,  3'd2, 0,0));
        vecs.push_back(mk("fill3",     0,0,0,1,0,0, 6'd3,    6'd3,  3'd3, 0,0));
        vecs.push_back(mk("fill4",     0,0,0,1,0,0, 6'd4,    6'd4,  3'd4, 0,0));
        vecs.push_back(mk("overflow",  0,0,0,1,0,0, 6'd5,    6'd4,  3'd4, 1,0));

        // Drain the stack in LIFO order, then underflow it.
        vecs.push_back(mk("drain4",    0,0,0,0,1,0, 6'd0,    6'd4,  3'd3, 1,0));
        vecs.push_back(mk("drain3",    0,0,0,0,1,0, 6'd0,    6'd3,  3'd2, 1,0));
        vecs.push_back(mk("drain2",    0,0,0,0,1,0, 6'd0,    6'd2,  3'd1, 1,0));
        vecs.push_back(mk("drain1",    0,0,0,0,1,0, 6'd0,    6'd1,  3'd0, 1,0));
        vecs.push_back(mk("underflow", 0,0,0,0,1,0, 6'd0,    6'd1,  3'd0, 1,1));
        vecs.push_back(mk("sticky",    1,0,0,0,0,0, 6'd0,    6'd2,  3'd0, 1,1));

        // Stall with call+ret+inc pending, then release so that only ret executes.
        vecs.push_back(mk("call30",    0,0,0,1,0,0, 6'd30,   6'd30, 3'd1, 1,1));
        vecs.push_back(mk("stall_a",   1,0,0,1,1,1, 6'd7,    6'd30, 3'd1, 1,1));
        vecs.push_back(mk("stall_b",   1,0,0,1,1,1, 6'd7,    6'd30, 3'd1, 1,1));
        vecs.push_back(mk("stall_c",   1,0,0,1,1,1, 6'd7,    6'd30, 3'd1, 1,1));
        vecs.push_back(mk("release",   1,0,0,1,1,0, 6'd7,    6'd3,  3'd0, 1,1));
        vecs.push_back(mk("stall_abs", 0,1,0,0,0,1, 6'd44,   6'd3,  3'd0, 1,1));

        // Reset, and check the reset state.
        drive(0,0,0,0,0,0, 6'd0);
        nRst = 1'b0;
        #12;
        check_state("reset", 6'd0, 3'd0, 0, 0);
        @(negedge clk);
        nRst = 1'b1;

        // Test 1: 70 increments walk 1..63, then wrap through 0..6.
        for (int i = 1; i <= 70; i++) begin
            step(1,0,0,0,0,0, 6'd0);
            check($sformatf("inc%0d", i), 32'(address), 32'(i % 64));
        end
        check("inc.depth", 32'(depth), 32'd0);

        // Table-driven vectors.
        foreach (vecs[k]) begin
            step(vecs[k].inc, vecs[k].abs_b, vecs[k].rel_b, vecs[k].call_b,
                 vecs[k].ret_b, vecs[k].stall_b, vecs[k].ba);
            check_state(vecs[k].name, vecs[k].e_addr, vecs[k].e_depth,
                        vecs[k].e_ovf, vecs[k].e_unf);
        end

        // Assert reset asynchronously in the middle of a stalled cycle.
        step(0,0,0,1,0,0, 6'd9);
        check_state("pre_rst", 6'd9, 3'd1, 1, 1);
        @(negedge clk);
        drive(1,0,0,1,1,1, 6'd7);
        @(posedge clk);
        #3;
        nRst = 1'b0;
        #1;
        check_state("async_rst", 6'd0, 3'd0, 0, 0);
        @(negedge clk);
        nRst = 1'b1;
        step(1,0,0,0,0,0, 6'd0);
        check_state("post_rst", 6'd1, 3'd0, 0, 0);

`ifdef SEQ_LOOP_EN
        // Hardware loop: at address 2, loopSet with end=4 and count=3.
        step(0,1,0,0,0,0, 6'd2);
        @(negedge clk);
        drive(0,0,0,0,0,0, 6'd4);
        loopSet   = 1'b1;
        loopCount = 8'd3;
        @(posedge clk);
        #1;
        check("loopset.address", 32'(address), 32'd3);
        check("loopset.active", 32'(loopActive), 32'd1);
        begin
            logic [5:0] exp_seq [6];
            logic       exp_act [6];
            exp_seq = '{6'd4, 6'd3, 6'd4, 6'd3, 6'd4, 6'd5};
            exp_act = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
            for (int i = 0; i < 6; i++) begin
                step(1,0,0,0,0,0, 6'd0);
                check($sformatf("loop%0d.address", i), 32'(address), 32'(exp_seq[i]));
                check($sformatf("loop%0d.active", i), 32'(loopActive), 32'(exp_act[i]));
            end
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
